stream_prefetcher: RTL and testbench

//   Parametrised sequential-stream read prefetcher placed between a CPU port and
//   its cache (one instance per I-cache / D-cache). Cache-agnostic. After each

---
 rtl/stream_prefetcher.sv | 111 +++++++++++
 tb/tb_stream_prefetcher.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_prefetcher.sv
// rtl/stream_prefetcher.sv - sequential next-line read prefetcher between a CPU port and its cache
// Demand reads pass through combinationally; after each one the stream is topped up to DEGREE lines ahead.
module stream_prefetcher #(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 32,
   parameter int DEGREE     = 2,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pf_enable,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_read,
   input  logic              cpu_write,
   output logic              cpu_resp,
   output logic [ADDR_W-1:0] cache_addr,
   output logic              cache_read,
   output logic              cache_write,
   input  logic              cache_resp,
   output logic [CNT_W-1:0]  pf_count
);

   localparam int OFF    = $clog2(LINE_BYTES);
   localparam int LINE_W = ADDR_W - OFF;
   localparam int LEFT_W = $clog2(DEGREE + 2);
   localparam logic [LINE_W-1:0] MAX_LEAD = LINE_W'(DEGREE + 1);
   localparam logic [LEFT_W-1:0] DEG_L    = LEFT_W'(DEGREE);

   typedef enum logic {
      NORMAL   = 1'b0,
      PREFETCH = 1'b1
   } state_t;

   state_t             state, state_nx;
   logic               pf_valid, pf_valid_nx;
   logic [LINE_W-1:0]  pf_next, pf_next_nx;
   logic [LEFT_W-1:0]  pf_left, pf_left_nx;
   logic [CNT_W-1:0]   pf_count_nx;
   logic [LINE_W-1:0]  cpu_line;
   logic [LINE_W-1:0]  lead;
   logic [LEFT_W-1:0]  left_dec;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= NORMAL;
         pf_valid <= 1'b0;
         pf_next  <= '0;
         pf_left  <= '0;
         pf_count <= '0;
      end else begin
         state    <= state_nx;
         pf_valid <= pf_valid_nx;
         pf_next  <= pf_next_nx;
         pf_left  <= pf_left_nx;
         pf_count <= pf_count_nx;
      end
   end

   always_comb begin
      cpu_line    = cpu_addr[ADDR_W-1:OFF];
      // Modular distance, so a stream that wraps through line 0 still counts as a hit.
      lead        = pf_next - cpu_line;
      left_dec    = pf_left - LEFT_W'(1);

      state_nx    = state;
      pf_valid_nx = pf_valid;
      pf_next_nx  = pf_next;
      pf_left_nx  = pf_left;
      pf_count_nx = pf_count;

      cache_addr  = cpu_addr;
      cache_read  = cpu_read;
      cache_write = cpu_write;
      cpu_resp    = cache_resp;

      case (state)
         NORMAL: begin
            if (cpu_read && cache_resp) begin
               if (pf_valid && (lead != '0) && (lead <= MAX_LEAD)) begin
                  pf_left_nx = LEFT_W'(MAX_LEAD - lead);
               end else begin
                  pf_next_nx  = cpu_line + LINE_W'(1);
                  pf_left_nx  = DEG_L;
                  pf_valid_nx = 1'b1;
               end
               if (pf_enable && (pf_left_nx != '0)) state_nx = PREFETCH;
            end
         end
         PREFETCH: begin
            // CPU requests stall here; the prefetch owns the cache port until its response.
            cache_addr  = {pf_next, {OFF{1'b0}}};
            cache_read  = 1'b1;
            cache_write = 1'b0;
            cpu_resp    = 1'b0;
            if (cache_resp) begin
               pf_next_nx  = pf_next + LINE_W'(1);
               pf_left_nx  = left_dec;
               pf_count_nx = pf_count + CNT_W'(1);
               if (cpu_read || cpu_write) begin
                  state_nx   = NORMAL;
                  pf_left_nx = '0;
               end else if (!pf_enable || (left_dec == '0)) begin
                  state_nx = NORMAL;
               end
            end
         end
         default: state_nx = NORMAL;
      endcase
   end

endmodule

// File: tb/tb_stream_prefetcher.sv
// tb/tb_stream_prefetcher.sv - directed self-checking bench for stream_prefetcher
// A small fixed-latency cache model logs every request it accepts.
module tb_stream_prefetcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        pf_enable;
   logic [31:0] cpu_addr;
   logic        cpu_read;
   logic        cpu_write;
   logic        cpu_resp;
   logic [31:0] cache_addr;
   logic        cache_read;
   logic        cache_write;
   logic        cache_resp;
   logic [31:0] pf_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] log_addr[$];
   logic        log_wr[$];
   logic [31:0] exp[$];
   logic [31:0] got;
   logic        busy;
   int          wait_cnt;
   int          resp_cnt = 0;
   int          both_cnt = 0;

   stream_prefetcher #(
      .ADDR_W(32), .LINE_BYTES(32), .DEGREE(2), .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst), .pf_enable(pf_enable),
      .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_resp(cpu_resp),
      .cache_addr(cache_addr), .cache_read(cache_read), .cache_write(cache_write),
      .cache_resp(cache_resp), .pf_count(pf_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         cache_resp <= 1'b0;
         busy       <= 1'b0;
         wait_cnt   <= 0;
      end else begin
         cache_resp <= 1'b0;
         if (cache_resp) begin
            busy <= 1'b0;
         end else if (busy) begin
            if (wait_cnt == 0) cache_resp <= 1'b1;
            else wait_cnt <= wait_cnt - 1;
         end else if (cache_read || cache_write) begin
            busy     <= 1'b1;
            wait_cnt <= 1;
            log_addr.push_back(cache_addr);
            log_wr.push_back(cache_write);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && cpu_resp === 1'b1) resp_cnt <= resp_cnt + 1;
      if (cache_read === 1'b1 && cache_write === 1'b1) both_cnt <= both_cnt + 1;
   end

   task automatic demand(input logic [31:0] a, input logic wr, input string name);
      int n;
      cpu_addr  = a;
      cpu_read  = !wr;
      cpu_write = wr;
      n = 0;
      @(negedge clk);
      while (cpu_resp !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (cpu_resp !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_resp: cpu_resp=%b after %0d cycles, required 1", name, cpu_resp, n);
      end
      @(posedge clk);
      #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pf_enable = 1'b1;
      cpu_addr = '0;
      cpu_read = 1'b0;
      cpu_write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (cache_read !== 1'b0 || cache_write !== 1'b0 || cpu_resp !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: rd=%b wr=%b resp=%b, required 0 0 0", cache_read, cache_write, cpu_resp);
      end
      n_cmp++;
      if (pf_count !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_pf_count: got %0d, required 0", pf_count);
      end
      cpu_addr = 32'h1234;
      cpu_read = 1'b1;
      #1;
      n_cmp++;
      if (cache_addr !== 32'h1234 || cache_read !== 1'b1 || cache_write !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_passthru_rd: addr=%h rd=%b wr=%b, required 1234 1 0", cache_addr, cache_read, cache_write);
      end
      cpu_read = 1'b0;
      cpu_write = 1'b1;
      #1;
      n_cmp++;
      if (cache_write !== 1'b1 || cache_read !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_passthru_wr: rd=%b wr=%b, required 0 1", cache_read, cache_write);
      end
      cpu_write = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_first_stream();
      int r0;
      log_addr.delete();
      log_wr.delete();
      r0 = resp_cnt;
      demand(32'h100, 1'b0, "t1");
      idle(30);
      exp = '{32'h100, 32'h120, 32'h140};
      n_cmp++;
      if (log_addr.size() != exp.size()) begin
         n_bad++;
         $display("FAIL t1_log_len: got %0d, required %0d", log_addr.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < log_addr.size()) ? log_addr[i] : 32'hx;
         n_cmp++;
         if (got !== exp[i]) begin
            n_bad++;
            $display("FAIL t1_log[%0d]: got %h, required %h", i, got, exp[i]);
         end
      end
      n_cmp++;
      if (pf_count !== 32'd2) begin
         n_bad++;
         $display("FAIL t1_pf_count: got %0d, required 2", pf_count);
      end
      n_cmp++;
      if (resp_cnt - r0 != 1) begin
         n_bad++;
         $display("FAIL t1_cpu_resp_pulses: got %0d, required 1", resp_cnt - r0);
      end
      n_cmp++;
      if (cache_read !== 1'b0) begin
         n_bad++;
         $display("FAIL t1_back_to_normal: cache_read=%b, required 0", cache_read);
      end
   endtask

   task automatic test_stream_hit();
      log_addr.delete();
      log_wr.delete();
      demand(32'h120, 1'b0, "t2a");
      idle(30);
      exp = '{32'h120, 32'h160};
      n_cmp++;
      if (log_addr.size() != exp.size()) begin
         n_bad++;
         $display("FAIL t2a_log_len: got %0d, required %0d", log_addr.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < log_addr.size()) ? log_addr[i] : 32'hx;
         n_cmp++;
         if (got !== exp[i]) begin
            n_bad++;
            $display("FAIL t2a_log[%0d]: got %h, required %h", i, got, exp[i]);
         end
      end
      n_cmp++;
      if (pf_count !== 32'd3) begin
         n_bad++;
         $display("FAIL t2a_pf_count: got %0d, required 3", pf_count);
      end
      log_addr.delete();
      log_wr.delete();
      demand(32'h120, 1'b0, "t2b");
      idle(30);
      n_cmp++;
      if (log_addr.size() != 1) begin
         n_bad++;
         $display("FAIL t2b_log_len: got %0d, required 1", log_addr.size());
      end
      n_cmp++;
      if (pf_count !== 32'd3) begin
         n_bad++;
         $display("FAIL t2b_pf_count: got %0d, required 3", pf_count);
      end
   endtask

   task automatic test_back_to_back();
      log_addr.delete();
      log_wr.delete();
      demand(32'h100, 1'b0, "t3a");
      n_cmp++;
      if (cache_read !== 1'b1 || cache_addr !== 32'h120 || cpu_resp !== 1'b0) begin
         n_bad++;
         $display("FAIL t3_prefetch_addr: rd=%b addr=%h resp=%b, required 1 120 0", cache_read, cache_addr, cpu_resp);
      end
      demand(32'h800, 1'b0, "t3b");
      idle(30);
      exp = '{32'h100, 32'h120, 32'h800, 32'h820, 32'h840};
      n_cmp++;
      if (log_addr.size() != exp.size()) begin
         n_bad++;
         $display("FAIL t3_log_len: got %0d, required %0d", log_addr.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < log_addr.size()) ? log_addr[i] : 32'hx;
         n_cmp++;
         if (got !== exp[i]) begin
            n_bad++;
            $display("FAIL t3_log[%0d]: got %h, required %h", i, got, exp[i]);
         end
      end
      n_cmp++;
      if (pf_count !== 32'd6) begin
         n_bad++;
         $display("FAIL t3_pf_count: got %0d, required 6", pf_count);
      end
   endtask

   task automatic test_wrap();
      log_addr.delete();
      log_wr.delete();
      demand(32'hFFFF_FFE0, 1'b0, "t4a");
      idle(30);
      exp = '{32'hFFFF_FFE0, 32'h0000_0000, 32'h0000_0020};
      n_cmp++;
      if (log_addr.size() != exp.size()) begin
         n_bad++;
         $display("FAIL t4a_log_len: got %0d, required %0d", log_addr.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < log_addr.size()) ? log_addr[i] : 32'hx;
         n_cmp++;
         if (got !== exp[i]) begin
            n_bad++;
            $display("FAIL t4a_log[%0d]: got %h, required %h", i, got, exp[i]);
         end
      end
      log_addr.delete();
      log_wr.delete();
      demand(32'h0000_0000, 1'b0, "t4b");
      idle(30);
      exp = '{32'h0000_0000, 32'h0000_0040};
      n_cmp++;
      if (log_addr.size() != exp.size()) begin
         n_bad++;
         $display("FAIL t4b_log_len: got %0d, required %0d", log_addr.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < log_addr.size()) ? log_addr[i] : 32'hx;
         n_cmp++;
         if (got !== exp[i]) begin
            n_bad++;
            $display("FAIL t4b_log[%0d]: got %h, required %h", i, got, exp[i]);
         end
      end
      n_cmp++;
      if (pf_count !== 32'd9) begin
         n_bad++;
         $display("FAIL t4_pf_count: got %0d, required 9", pf_count);
      end
   endtask

   task automatic test_disabled_and_writes();
      pulse_reset();
      pf_enable = 1'b0;
      log_addr.delete();
      log_wr.delete();
      demand(32'h200, 1'b0, "t5a");
      demand(32'h100, 1'b1, "t5b");
      demand(32'h220, 1'b0, "t5c");
      idle(30);
      exp = '{32'h200, 32'h100, 32'h220};
      n_cmp++;
      if (log_addr.size() != exp.size()) begin
         n_bad++;
         $display("FAIL t5_log_len: got %0d, required %0d", log_addr.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < log_addr.size()) ? log_addr[i] : 32'hx;
         n_cmp++;
         if (got !== exp[i]) begin
            n_bad++;
            $display("FAIL t5_log[%0d]: got %h, required %h", i, got, exp[i]);
         end
      end
      n_cmp++;
      if (log_wr.size() < 2 || log_wr[1] !== 1'b1 || log_wr[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL t5_write_kind: entries=%0d, required write at index 1 only", log_wr.size());
      end
      n_cmp++;
      if (pf_count !== 32'd0) begin
         n_bad++;
         $display("FAIL t5_pf_count_disabled: got %0d, required 0", pf_count);
      end
      pf_enable = 1'b1;
      log_addr.delete();
      log_wr.delete();
      demand(32'h100, 1'b1, "t5d");
      idle(30);
      n_cmp++;
      if (log_addr.size() != 1) begin
         n_bad++;
         $display("FAIL t5_write_no_prefetch: log entries %0d, required 1", log_addr.size());
      end
      n_cmp++;
      if (pf_count !== 32'd0) begin
         n_bad++;
         $display("FAIL t5_pf_count_write: got %0d, required 0", pf_count);
      end
   endtask

   task automatic test_reset_mid_prefetch();
      pf_enable = 1'b1;
      demand(32'h300, 1'b0, "t6a");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (cache_read !== 1'b0) begin
         n_bad++;
         $display("FAIL t6_read_dropped: cache_read=%b, required 0", cache_read);
      end
      n_cmp++;
      if (pf_count !== 32'd0) begin
         n_bad++;
         $display("FAIL t6_pf_count: got %0d, required 0", pf_count);
      end
      cpu_addr = 32'h500;
      cpu_read = 1'b1;
      #1;
      n_cmp++;
      if (cache_read !== 1'b1 || cache_addr !== 32'h500) begin
         n_bad++;
         $display("FAIL t6_passthru: rd=%b addr=%h, required 1 500", cache_read, cache_addr);
      end
      cpu_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      log_addr.delete();
      log_wr.delete();
      demand(32'hFFFF_FFA0, 1'b0, "t6b");
      idle(30);
      exp = '{32'hFFFF_FFA0, 32'hFFFF_FFC0, 32'hFFFF_FFE0};
      n_cmp++;
      if (log_addr.size() != exp.size()) begin
         n_bad++;
         $display("FAIL t6_log_len: got %0d, required %0d", log_addr.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < log_addr.size()) ? log_addr[i] : 32'hx;
         n_cmp++;
         if (got !== exp[i]) begin
            n_bad++;
            $display("FAIL t6_log[%0d]: got %h, required %h", i, got, exp[i]);
         end
      end
      n_cmp++;
      if (pf_count !== 32'd2) begin
         n_bad++;
         $display("FAIL t6_pf_count_restart: got %0d, required 2", pf_count);
      end
   endtask

   initial begin
      test_reset();
      test_first_stream();
      test_stream_hit();
      test_back_to_back();
      test_wrap();
      test_disabled_and_writes();
      test_reset_mid_prefetch();
      n_cmp++;
      if (both_cnt != 0) begin
         n_bad++;
         $display("FAIL read_write_exclusive: overlapping cycles %0d, required 0", both_cnt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
